// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the line responder
package mem_pkg;

  localparam int LINE_BITS  = 128;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [27:0] line_base(input logic [31:0] addr);
    return addr[31:4];
  endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// rtl/mem_line_responder_if.sv - cache-side request/response channels
interface mem_line_responder_if;
  import mem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_we;
  logic [LINE_BITS-1:0] resp_line;
  logic                 resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_we, resp_line, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_we, resp_line, resp_err
  );

endinterface

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - DEPTH x 32 word store, one write port, one 4-word line read port
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [31:0]          wdata,
  input  logic [AW-3:0]        rline,
  output logic [LINE_BITS-1:0] rdata
);

  // Not reset: preloaded contents must survive a reset pulse.
  logic [31:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_line
    assign rdata[32*g +: 32] = data_mem[{rline, 2'(g)}];
  end

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - fixed-latency line-fill / write-through responder; MEM_RESP_PERF_EN adds perf counters
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_line_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  state_t               state;
  logic [3:0]           cnt;
  logic                 cap_we;
  logic [31:0]          cap_addr;
  logic [31:0]          cap_wdata;
  logic [29:0]          cap_widx;
  logic [27:0]          cap_line;
  logic                 in_range;
  logic                 accept;
  logic                 arr_we;
  logic [LINE_BITS-1:0] rd_line;
  logic                 unused_bits;

  assign cap_widx    = cap_addr[31:2];
  assign cap_line    = line_base(cap_addr);
  assign in_range    = cap_widx < 30'(DEPTH);
  assign accept      = (state == IDLE) && bus.req_ready && bus.req_valid;
  assign unused_bits = ^{cap_addr[1:0], cap_line[27:AW-2]};

  // A reset landing on the access edge must not commit the write.
  assign arr_we = (state == WAIT) && (cnt == 4'd0) && cap_we && in_range && !reset;

  mem_word_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (cap_widx[AW-1:0]),
    .wdata (cap_wdata),
    .rline (cap_line[AW-3:0]),
    .rdata (rd_line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_we    <= 1'b0;
      bus.resp_line  <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (accept) begin
            cap_we        <= bus.req_we;
            cap_addr      <= bus.req_addr;
            cap_wdata     <= bus.req_wdata;
            cnt           <= 4'(LATENCY - 1);
            bus.req_ready <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_we    <= cap_we;
            bus.resp_err   <= !in_range;
            bus.resp_line  <= (!cap_we && in_range) ? rd_line : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESP_PERF_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [31:0] stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count     <= '0;
      wr_count     <= '0;
      stall_cycles <= '0;
    end else begin
      if (accept && !bus.req_we && rd_count != '1) begin
        rd_count <= rd_count + 32'd1;
      end
      if (accept && bus.req_we && wr_count != '1) begin
        wr_count <= wr_count + 32'd1;
      end
      if (state != IDLE && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - directed bench with a transaction-level model of the responder
module tb_mem_line_responder;
  import mem_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_line_responder_if ifc();

  mem_line_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0]  mmem [DEPTH];
  logic         m_ready   = 1'b0;
  logic         m_valid   = 1'b0;
  logic         m_pending = 1'b0;
  int           age       = 0;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wd;
  logic [127:0] m_line;
  logic         m_err;
  int           acc_cnt   = 0;
  logic         started   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] model_line(input logic [31:0] a);
    int idx;
    int b;
    idx = int'(a[31:2]);
    if (idx >= DEPTH) return '0;
    b = idx - (idx % 4);
    return {mmem[b+3], mmem[b+2], mmem[b+1], mmem[b]};
  endfunction

  // Transaction model: one outstanding request, response visible LAT edges after acceptance.
  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      m_ready   = 1'b0;
      m_valid   = 1'b0;
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (m_valid) begin
        if (ifc.resp_ready) begin
          m_pending = 1'b0;
          m_valid   = 1'b0;
          m_ready   = 1'b1;
        end
      end else begin
        age++;
        if (age == LAT) begin
          m_valid = 1'b1;
          m_err   = int'(m_addr[31:2]) >= DEPTH;
          if (m_we) begin
            if (!m_err) mmem[m_addr[31:2]] = m_wd;
            m_line = '0;
          end else begin
            m_line = model_line(m_addr);
          end
        end
      end
    end else if (m_ready && ifc.req_valid) begin
      m_we      = ifc.req_we;
      m_addr    = ifc.req_addr;
      m_wd      = ifc.req_wdata;
      m_pending = 1'b1;
      m_ready   = 1'b0;
      age       = 0;
      acc_cnt++;
    end else begin
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", 128'(ifc.req_ready), 128'(m_ready));
      chk("resp_valid", 128'(ifc.resp_valid), 128'(m_valid));
      if (m_valid) begin
        chk("resp_we", 128'(ifc.resp_we), 128'(m_we));
        chk("resp_line", ifc.resp_line, m_line);
        chk("resp_err", 128'(ifc.resp_err), 128'(m_err));
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input logic hold, input logic [127:0] exp_line,
                        input logic exp_err, input string tag);
    int a0;
    int lat;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_we    = we;
    ifc.req_addr  = addr;
    ifc.req_wdata = wd;
    a0 = acc_cnt;
    for (int i = 0; i < 20 && acc_cnt == a0; i++) @(negedge clk);
    chk({tag, "_accepted"}, 128'(acc_cnt != a0), 128'(1));
    if (hold) ifc.req_addr = addr ^ 32'h0000_1000;
    else ifc.req_valid = 1'b0;
    lat = 0;
    while (!ifc.resp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    ifc.req_valid = 1'b0;
    chk({tag, "_latency"}, 128'(lat), 128'(LAT));
    chk({tag, "_line"}, ifc.resp_line, exp_line);
    chk({tag, "_err"}, 128'(ifc.resp_err), 128'(exp_err));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, "_bp_line"}, ifc.resp_line, exp_line);
      chk({tag, "_bp_ready"}, 128'(ifc.req_ready), 128'(0));
    end
    ifc.resp_ready = 1'b1;
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    chk({tag, "_ready_after"}, 128'(ifc.req_ready), 128'(1));
  endtask

  localparam logic [127:0] PRE_LINE = 128'hAAAA3333_AAAA2222_AAAA1111_AAAA0000;
  localparam logic [127:0] NEW_LINE = 128'hAAAA3333_AAAA2222_AAAA1111_DEADBEEF;

  initial begin
    int a0;
    for (int i = 0; i < DEPTH; i++) begin
      mmem[i] = '0;
    end
    mmem[0]    = 32'h1234_5678;
    mmem[1024] = 32'hAAAA_0000;
    mmem[1025] = 32'hAAAA_1111;
    mmem[1026] = 32'hAAAA_2222;
    mmem[1027] = 32'hAAAA_3333;
    mmem[3072] = 32'hCCCC_0000;
    for (int i = 0; i < DEPTH; i++) begin
      dut.u_array.data_mem[i] = mmem[i];
    end
    ifc.req_valid  = 1'b0;
    ifc.req_we     = 1'b0;
    ifc.req_addr   = '0;
    ifc.req_wdata  = '0;
    ifc.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 128'(ifc.req_ready), 128'(0));
    chk("rst_resp_valid", 128'(ifc.resp_valid), 128'(0));
    chk("rst_resp_we", 128'(ifc.resp_we), 128'(0));
    chk("rst_resp_line", ifc.resp_line, 128'(0));
    chk("rst_resp_err", 128'(ifc.resp_err), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("release_req_ready", 128'(ifc.req_ready), 128'(1));

    do_req(1'b0, 32'h0000_1008, 32'h0, 0, 1'b0, PRE_LINE, 1'b0, "rd_line");
    do_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0, 128'h0, 1'b0, "wr");
    do_req(1'b0, 32'h0000_1000, 32'h0, 0, 1'b0, NEW_LINE, 1'b0, "raw");
    chk("mem1024", 128'(dut.u_array.data_mem[1024]), 128'(32'hDEAD_BEEF));
    do_req(1'b0, 32'h0000_100F, 32'h0, 6, 1'b0, NEW_LINE, 1'b0, "bp");
    do_req(1'b0, 32'h0000_1004, 32'h0, 0, 1'b1, NEW_LINE, 1'b0, "hold");
    repeat (3) @(negedge clk);
    chk("hold_no_second", 128'(ifc.resp_valid), 128'(0));
    do_req(1'b0, 32'h0001_0000, 32'h0, 0, 1'b0, 128'h0, 1'b1, "oor_rd");
    do_req(1'b1, 32'h0001_0000, 32'h5555_5555, 0, 1'b0, 128'h0, 1'b1, "oor_wr");
    chk("oor_mem0", 128'(dut.u_array.data_mem[0]), 128'(32'h1234_5678));
    do_req(1'b0, 32'h0000_0002, 32'h0, 0, 1'b0, 128'h1234_5678, 1'b0, "rd0");

    // Reset during WAIT must discard the pending write.
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b1;
    ifc.req_addr  = 32'h0000_3000;
    ifc.req_wdata = 32'hFACE_FEED;
    a0 = acc_cnt;
    for (int i = 0; i < 20 && acc_cnt == a0; i++) @(negedge clk);
    chk("rst_wr_accepted", 128'(acc_cnt != a0), 128'(1));
    ifc.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 128'(ifc.req_ready), 128'(1));
    chk("midrst_resp_valid", 128'(ifc.resp_valid), 128'(0));
    repeat (6) @(negedge clk);
    chk("midrst_mem3072", 128'(dut.u_array.data_mem[3072]), 128'(32'hCCCC_0000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
